decoder_lane_arbiter: RTL and testbench
=======================================

// Module: decoder_lane_arbiter
// PURPOSE
//  Shares one downstream decoder datapath between NUM_LANES decoder_fifo output streams.
//  Round-robin arbiter with per-grant burst limit and lane enable mask; registered AXIS output.
//  Sits in the m_axis_aclk domain after the per-lane decoder FIFOs, ahead of the common consumer.
// PARAMETERS
//  NUM_LANES  4   number of requesting AXIS lanes (>=2)
//  DWIDTH     64  tdata width per lane and output
//  MAX_BURST  16  largest beats per grant; burst_len width BLW = $clog2(MAX_BURST+1)
// PORTS
//  aclk               in   1                 single clock, all logic rising edge
//  rst                in   1                 asynchronous, active-high reset
//  s_axis_tdata       in   NUM_LANES*DWIDTH  lane i data at [i*DWIDTH +: DWIDTH]
//  s_axis_tvalid      in   NUM_LANES         per-lane valid
//  s_axis_tready      out  NUM_LANES         per-lane ready (one-hot or zero)
//  m_axis_tdata       out  DWIDTH            arbitrated data, registered
//  m_axis_tvalid      out  1                 registered valid
//  m_axis_tready      in   1                 downstream ready
//  lane_en            in   NUM_LANES         lane i may be granted when 1
//  burst_len          in   BLW               beats per grant; 0 treated as 1; >MAX_BURST clamps to MAX_BURST
//  grant_valid        out  1                 a lane currently owns the output
//  grant_id           out  $clog2(NUM_LANES) owning lane (held after release)
// BEHAVIOUR
//  Reset: m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0, grant_valid=0, grant_id=0,
//   beat_cnt=0, last_grant=NUM_LANES-1 (lane 0 wins first), state=IDLE. Reset mid-burst drops grant, no data flushed out.
//  FSM states: IDLE, GRANT.
//  IDLE: req = s_axis_tvalid & lane_en. If req!=0, pick first set bit searching last_grant+1 upward with
//   wrap; register grant_id, grant_valid=1, latch eff_len=sat(burst_len), beat_cnt=0 -> GRANT. No transfer in IDLE.
//  GRANT (lane g): s_axis_tready[g] = lane_en[g] & (~m_axis_tvalid | m_axis_tready); others 0.
//   Accepted beat (tvalid&tready on g): m_axis_tdata<=lane g data, m_axis_tvalid<=1, beat_cnt++.
//   Release -> IDLE, last_grant<=g, grant_valid<=0 when any of:
//    a) accepted beat with beat_cnt==eff_len-1 (burst done, beat still delivered);
//    b) s_axis_tvalid[g]==0 this cycle (lane drained; decoder FIFO bubbles end the grant);
//    c) lane_en[g]==0 this cycle (no beat accepted).
//  Output reg: if m_axis_tready & m_axis_tvalid and no new beat loads, m_axis_tvalid<=0; data held.
//   Full throughput: load and drain same cycle allowed. m_axis_tdata stable while tvalid & ~tready.
//  Latency: lane beat appears on m_axis one cycle after acceptance. Arbitration costs 1 idle cycle per grant
//   (max sustained rate eff_len/(eff_len+1) with >=2 busy lanes).
//  Fairness: lane waiting with tvalid & lane_en is served within NUM_LANES-1 grants.
//  burst_len/lane_en changes mid-burst: burst_len ignored until next grant; lane_en takes effect next cycle.
//  Single requester: re-granted after 1 IDLE cycle. No requesters: remains IDLE, s_axis_tready=0.
//  Never asserts more than one s_axis_tready bit; never accepts a beat when output reg full and not draining.
// STRUCTURE
//  Package decoder_arb_pkg: typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t; function sat_burst()
//   (0->1, clamp MAX_BURST); lane index width helper.
//  Sub-module decoder_rr_picker (combinational): req[NUM_LANES], last[$clog2(NUM_LANES)] -> found, idx.
//  Top holds FSM, beat counter, grant regs, output register.
// TESTING
//  1. Reset, lane0 only valid, burst_len=4, m_tready=1 -> IDLE 1 cyc, 4 beats lane0 back-to-back, 1 gap, repeat.
//  2. All 4 lanes valid, burst_len=2 -> grant_id sequence 0,1,2,3,0; 2 beats each; one gap between grants.
//  3. Lane1 grant, m_tready held 0 for 5 cycles after 1st beat -> m_tdata/tvalid stable, s_tready[1]=0, no beat lost.
//  4. Lane2 granted burst_len=8, drops tvalid after 3 beats -> release, next grant lane3; lane2 served later.
//  5. lane_en=4'b1010, all valid -> only lanes 1,3 granted alternately; clear lane_en[3] mid-burst -> release next cycle.
//  6. burst_len=0 -> 1 beat/grant; burst_len=31 (MAX_BURST=16) -> 16 beats; assert rst mid-burst -> all outputs reset immediately.
//  Scoreboard per-lane order/data; assertions: s_axis_tready onehot0, AXIS stability on m_axis.

Source files
------------

// File: rtl/decoder_lane_arbiter_pkg.sv
// Shared types and helpers for the decoder lane arbiter: FSM state encoding,
// burst-length saturation and lane index width.
package decoder_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    function automatic int lane_idx_w(input int numLanes);
        return (numLanes > 1) ? $clog2(numLanes) : 1;
    endfunction

    // A zero request still moves one beat; oversize requests are clamped.
    function automatic int sat_burst(input int len, input int maxBurst);
        if (len == 0) begin
            return 1;
        end
        if (len > maxBurst) begin
            return maxBurst;
        end
        return len;
    endfunction

endpackage

// File: rtl/decoder_lane_arbiter_picker.sv
// Combinational round-robin picker: first requesting lane after i_last, with wrap.
module decoder_rr_picker
    import decoder_arb_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int LIW       = lane_idx_w(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] i_req,
    input  logic [LIW-1:0]       i_last,
    output logic                 o_found,
    output logic [LIW-1:0]       o_idx
);

    // Walk from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            if (i_req[(int'(i_last) + k) % NUM_LANES]) begin
                o_found = 1'b1;
                o_idx   = LIW'((int'(i_last) + k) % NUM_LANES);
            end
        end
    end

endmodule

// File: rtl/decoder_lane_arbiter.sv
// Round-robin arbiter sharing one AXIS decoder datapath between several lanes,
// with a per-grant burst limit, lane enable mask and a registered output stage.
module decoder_lane_arbiter
    import decoder_arb_pkg::*;
#(
    parameter int  NUM_LANES = 4,
    parameter int  DWIDTH    = 64,
    parameter int  MAX_BURST = 16,
    localparam int BLW       = $clog2(MAX_BURST + 1),
    localparam int LIW       = lane_idx_w(NUM_LANES)
) (
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [NUM_LANES*DWIDTH-1:0] s_axis_tdata,
    input  logic [NUM_LANES-1:0]        s_axis_tvalid,
    output logic [NUM_LANES-1:0]        s_axis_tready,
    output logic [DWIDTH-1:0]           m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic [NUM_LANES-1:0]        lane_en,
    input  logic [BLW-1:0]              burst_len,
    output logic                        grant_valid,
    output logic [LIW-1:0]              grant_id
);

    arb_state_t          r_state;
    logic [LIW-1:0]      r_grantId;
    logic [LIW-1:0]      r_lastGrant;
    logic                r_grantValid;
    logic [BLW-1:0]      r_beatCnt;
    logic [BLW-1:0]      r_effLen;
    logic [DWIDTH-1:0]   r_mTdata;
    logic                r_mTvalid;

    logic [NUM_LANES-1:0] w_req;
    logic                 w_found;
    logic [LIW-1:0]       w_pickIdx;
    logic                 w_outFree;
    logic                 w_laneValid;
    logic                 w_laneEn;
    logic                 w_accept;
    logic                 w_lastBeat;
    logic                 w_release;
    logic [DWIDTH-1:0]    w_laneData;
    logic [BLW-1:0]       w_effLenNext;
    logic [NUM_LANES-1:0] w_tready;

    assign w_req        = s_axis_tvalid & lane_en;
    assign w_outFree    = ~r_mTvalid | m_axis_tready;
    assign w_laneValid  = s_axis_tvalid[r_grantId];
    assign w_laneEn     = lane_en[r_grantId];
    assign w_laneData   = s_axis_tdata[r_grantId*DWIDTH +: DWIDTH];
    assign w_effLenNext = BLW'(sat_burst(int'(burst_len), MAX_BURST));

    // A bubble or a disabled lane ends the grant so other lanes are not starved.
    assign w_accept   = (r_state == ARB_GRANT) & w_laneEn & w_outFree & w_laneValid;
    assign w_lastBeat = w_accept & (r_beatCnt == (r_effLen - BLW'(1)));
    assign w_release  = (r_state == ARB_GRANT) & (w_lastBeat | ~w_laneValid | ~w_laneEn);

    decoder_rr_picker #(
        .NUM_LANES (NUM_LANES),
        .LIW       (LIW)
    ) u_picker (
        .i_req   (w_req),
        .i_last  (r_lastGrant),
        .o_found (w_found),
        .o_idx   (w_pickIdx)
    );

    always_comb begin
        w_tready = '0;
        if ((r_state == ARB_GRANT) && w_laneEn && w_outFree) begin
            w_tready[r_grantId] = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_IDLE;
            r_grantId    <= '0;
            r_lastGrant  <= LIW'(NUM_LANES - 1);
            r_grantValid <= 1'b0;
            r_beatCnt    <= '0;
            r_effLen     <= BLW'(1);
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_grantId    <= w_pickIdx;
                        r_grantValid <= 1'b1;
                        r_effLen     <= w_effLenNext;
                        r_beatCnt    <= '0;
                        r_state      <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_accept) begin
                        r_beatCnt <= r_beatCnt + BLW'(1);
                    end
                    if (w_release) begin
                        r_lastGrant  <= r_grantId;
                        r_grantValid <= 1'b0;
                        r_state      <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Output register: load and drain may happen in the same cycle.
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            r_mTdata  <= '0;
            r_mTvalid <= 1'b0;
        end else if (w_accept) begin
            r_mTdata  <= w_laneData;
            r_mTvalid <= 1'b1;
        end else if (m_axis_tready) begin
            r_mTvalid <= 1'b0;
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tdata  = r_mTdata;
    assign m_axis_tvalid = r_mTvalid;
    assign grant_valid   = r_grantValid;
    assign grant_id      = r_grantId;

endmodule

// File: tb/tb_decoder_lane_arbiter.sv
// Randomized bench for decoder_lane_arbiter against a transaction-level model:
// owner lane, beats left in the grant, and a one-deep queue for the output stage.
module tb_decoder_lane_arbiter;

    localparam int NL  = 4;
    localparam int DW  = 64;
    localparam int MB  = 16;
    localparam int BLW = $clog2(MB + 1);
    localparam int LIW = $clog2(NL);

    logic                 aclk = 1'b0;
    logic                 rst;
    logic [NL*DW-1:0]     sTdata;
    logic [NL-1:0]        sTvalid;
    logic [NL-1:0]        sTready;
    logic [DW-1:0]        mTdata;
    logic                 mTvalid;
    logic                 mTready;
    logic [NL-1:0]        laneEn;
    logic [BLW-1:0]       burstLen;
    logic                 grantValid;
    logic [LIW-1:0]       grantId;

    int numChecks = 0;
    int numPass   = 0;

    int          mOwner;
    int          mLast;
    int          mLeft;
    int          mId;
    logic [63:0] mQ[$];
    int          seq[NL];
    bit          prevStall;
    logic [63:0] prevData;

    decoder_lane_arbiter #(
        .NUM_LANES (NL),
        .DWIDTH    (DW),
        .MAX_BURST (MB)
    ) dut (
        .aclk          (aclk),
        .rst           (rst),
        .s_axis_tdata  (sTdata),
        .s_axis_tvalid (sTvalid),
        .s_axis_tready (sTready),
        .m_axis_tdata  (mTdata),
        .m_axis_tvalid (mTvalid),
        .m_axis_tready (mTready),
        .lane_en       (laneEn),
        .burst_len     (burstLen),
        .grant_valid   (grantValid),
        .grant_id      (grantId)
    );

    always #5 aclk = ~aclk;

    // Every lane emits a tagged, incrementing sequence so order and origin are visible.
    function automatic logic [63:0] dataOf(input int lane, input int s);
        return {8'(lane), 24'h5A5A5A, 32'(s)};
    endfunction

    function automatic int tbSat(input int len);
        if (len == 0) return 1;
        return (len > MB) ? MB : len;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        numChecks++;
        if (got === exp) begin
            numPass++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        mOwner    = -1;
        mLast     = NL - 1;
        mLeft     = 0;
        mId       = 0;
        mQ.delete();
        prevStall = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_tready"}, 64'(sTready), 64'd0);
        checkOutput({tag, "_grant_valid"}, 64'(grantValid), 64'd0);
        checkOutput({tag, "_grant_id"}, 64'(grantId), 64'd0);
        checkOutput({tag, "_m_tvalid"}, 64'(mTvalid), 64'd0);
        checkOutput({tag, "_m_tdata"}, 64'(mTdata), 64'd0);
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic modelStep();
        logic [NL-1:0] req;
        bit            outFree;
        bit            acc;
        outFree = (mQ.size() == 0) || mTready;
        if (mTready && mQ.size() > 0) void'(mQ.pop_front());
        if (mOwner < 0) begin
            req = sTvalid & laneEn;
            for (int k = 1; k <= NL; k++) begin
                int j;
                j = (mLast + k) % NL;
                if (mOwner < 0 && req[j]) begin
                    mOwner = j;
                    mId    = j;
                    mLeft  = tbSat(int'(burstLen));
                end
            end
        end else begin
            acc = laneEn[mOwner] && sTvalid[mOwner] && outFree;
            if (acc) begin
                mQ.push_back(dataOf(mOwner, seq[mOwner]));
                seq[mOwner]++;
                mLeft--;
            end
            if ((acc && mLeft == 0) || !sTvalid[mOwner] || !laneEn[mOwner]) begin
                mLast  = mOwner;
                mOwner = -1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [NL-1:0] vMask, input int vProb,
                                 input logic [NL-1:0] en, input int bl, input int rProb);
        logic [NL-1:0] expTready;
        @(posedge aclk);
        #1;
        for (int i = 0; i < NL; i++) begin
            sTvalid[i]            = vMask[i] && ($urandom_range(99) < vProb);
            sTdata[i*DW +: DW]    = dataOf(i, seq[i]);
        end
        laneEn   = en;
        burstLen = BLW'(bl);
        mTready  = ($urandom_range(99) < rProb);
        #1;
        expTready = '0;
        if (mOwner >= 0 && laneEn[mOwner] && (mQ.size() == 0 || mTready)) expTready[mOwner] = 1'b1;
        checkOutput("tready", 64'(sTready), 64'(expTready));
        checkOutput("tready_onehot0", 64'($onehot0(sTready)), 64'd1);
        checkOutput("grant_valid", 64'(grantValid), 64'(mOwner >= 0));
        checkOutput("grant_id", 64'(grantId), 64'(mId));
        checkOutput("m_tvalid", 64'(mTvalid), 64'(mQ.size() > 0));
        if (mQ.size() > 0) checkOutput("m_tdata", mTdata, mQ[0]);
        if (prevStall) begin
            checkOutput("stall_tvalid", 64'(mTvalid), 64'd1);
            checkOutput("stall_tdata", mTdata, prevData);
        end
        prevStall = mTvalid && !mTready;
        prevData  = mTdata;
        modelStep();
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic resetPulse();
        @(posedge aclk);
        #3;
        rst = 1'b1;
        #1;
        sTvalid = '0;
        laneEn  = '0;
        resetModel();
        checkResetState("midrst");
        @(posedge aclk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        sTdata   = '0;
        sTvalid  = '0;
        laneEn   = '0;
        burstLen = '0;
        mTready  = 1'b0;
        for (int i = 0; i < NL; i++) seq[i] = 0;
        resetModel();
        repeat (2) @(posedge aclk);
        #2;
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] lane0 alone, burst 4");
        repeat (30) applyStimulus(4'b0001, 100, 4'hF, 4, 100);
        $display("[TB] all lanes, burst 2");
        repeat (30) applyStimulus(4'b1111, 100, 4'hF, 2, 100);
        $display("[TB] lane1 with downstream stalls");
        repeat (40) applyStimulus(4'b0010, 100, 4'hF, 4, 30);
        $display("[TB] bursty lanes, burst 8");
        repeat (80) applyStimulus(4'b1111, 70, 4'hF, 8, 80);
        $display("[TB] enable mask 1010 then lane3 disabled");
        repeat (30) applyStimulus(4'b1111, 100, 4'b1010, 4, 100);
        repeat (10) applyStimulus(4'b1111, 100, 4'b0010, 4, 100);
        $display("[TB] burst 0 and burst 31");
        repeat (30) applyStimulus(4'b1111, 100, 4'hF, 0, 100);
        repeat (60) applyStimulus(4'b1111, 100, 4'hF, 31, 100);
        repeat (7) applyStimulus(4'b1111, 100, 4'hF, 31, 100);
        resetPulse();
        $display("[TB] random traffic");
        for (int p = 0; p < 12; p++) begin
            int bl;
            int vp;
            int rp;
            bl = $urandom_range(31);
            vp = $urandom_range(100, 40);
            rp = $urandom_range(100, 30);
            repeat (120) applyStimulus(4'($urandom), vp, 4'($urandom | 1), bl, rp);
            if (p == 5) resetPulse();
        end
        repeat (200) applyStimulus(4'hF, 85, 4'($urandom), $urandom_range(31), 75);

        $display("[TB] %0d/%0d checks passed", numPass, numChecks);
        $finish;
    end

endmodule
